// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared datapath width, ALU encodings and the per-instruction control bundle
package pipeline_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // Control bits that travel with an instruction through EX, MEM and WB.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/hazard_unit.sv
// hazard_unit: load-use detection against the EX stage and the ID stall equation
//   id_valid/id_rs1/id_rs2/id_uses_rs2 : instruction currently in ID
//   ex_valid/ex_mem_read/ex_rd         : instruction currently in EX
//   flush/hold_ex                      : branch redirect and EX back-pressure
//   hazard                             : load in EX feeds a source of the ID instruction
//   stall                              : freeze PC and IF/ID
module hazard_unit (
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       flush,
    input  logic       hold_ex,
    output logic       hazard,
    output logic       stall
);

    // x0 is never a real producer, so a load targeting it cannot cause a stall.
    assign hazard = id_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 &&
                    (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));

    // A flush discards the ID instruction anyway, so there is nothing to hold back.
    assign stall = (hazard || hold_ex) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB-to-ID bypass, load-use stall, flush/hold and bubble counter
//   id_*        : decoded instruction, register file read data and control from ID
//   wb_*        : write-back port, same signals that drive the register file
//   flush       : taken branch/jump resolved in EX, turns the EX entry into a bubble
//   hold_ex     : EX busy, EX register keeps its contents
//   stall_id    : freeze PC and IF/ID this cycle
//   ex_*        : registered EX stage inputs
//   bubble_cnt  : saturating count of bubbles inserted since reset
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [3:0]       id_alu_op,
    input  logic             id_alu_src,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic             id_reg_write,
    input  logic             id_mem_to_reg,
    input  logic             wb_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             flush,
    input  logic             hold_ex,
    output logic             stall_id,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_reg_write,
    output logic             ex_mem_to_reg,
    output logic [CNT_W-1:0] bubble_cnt
);

    import pipeline_pkg::*;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        ctrl_t           ctrl;
    } ex_t;

    ex_t             ex_q;
    ex_t             ex_d;
    ctrl_t           id_ctrl;
    logic [XLEN-1:0] rs1_eff;
    logic [XLEN-1:0] rs2_eff;
    logic            hazard;
    logic            stall;

    assign id_ctrl = '{alu_op: id_alu_op, alu_src: id_alu_src, mem_read: id_mem_read,
                       mem_write: id_mem_write, reg_write: id_reg_write, mem_to_reg: id_mem_to_reg};

    // The register file writes on the same edge this stage captures, so its read
    // port still shows the old value; forward the WB write data instead.
    assign rs1_eff = id_rs1 == 5'd0 ? '0 :
                     (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_data : id_rs1_data;
    assign rs2_eff = id_rs2 == 5'd0 ? '0 :
                     (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_data : id_rs2_data;

    always_comb begin
        ex_d = '{valid: id_valid, pc: id_pc, imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                 rs1_data: rs1_eff, rs2_data: rs2_eff, ctrl: id_valid ? id_ctrl : ctrl_t'(0)};
    end

    hazard_unit u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_q.valid),
        .ex_mem_read (ex_q.ctrl.mem_read),
        .ex_rd       (ex_q.rd),
        .flush       (flush),
        .hold_ex     (hold_ex),
        .hazard      (hazard),
        .stall       (stall)
    );

    // hold_ex can be high during reset; keep the stall quiet until the stage is live.
    assign stall_id = rst_n && stall;

    // flush beats hold_ex, hold_ex beats hazard; a bubble is an all-zero entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
        end else if (flush || (!hold_ex && hazard)) begin
            ex_q       <= '0;
            bubble_cnt <= bubble_cnt + CNT_W'(~&bubble_cnt);
        end else if (!hold_ex) begin
            ex_q       <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_pc         = ex_q.pc;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_alu_op     = ex_q.ctrl.alu_op;
    assign ex_alu_src    = ex_q.ctrl.alu_src;
    assign ex_mem_read   = ex_q.ctrl.mem_read;
    assign ex_mem_write  = ex_q.ctrl.mem_write;
    assign ex_reg_write  = ex_q.ctrl.reg_write;
    assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;

endmodule
